// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared constants, pixel types and helpers for the Sobel edge detector
package edge_pkg;

   localparam int H_ACTIVE = 640;
   localparam int PIX_W    = 8;
   localparam int LAT      = 3;
   localparam int X_W      = 10;
   localparam int Y_W      = 10;

   localparam int COEF_R = 77;
   localparam int COEF_G = 150;
   localparam int COEF_B = 29;

   typedef logic [23:0]      rgb_t;
   typedef logic [PIX_W-1:0] gray_t;

   // Coefficients sum to 256, so the top byte of the 16-bit sum never overflows.
   function automatic gray_t rgb_to_gray(input rgb_t c);
      logic [15:0] s;
      s = 16'(COEF_R) * 16'(c[23:16])
        + 16'(COEF_G) * 16'(c[15:8])
        + 16'(COEF_B) * 16'(c[7:0]);
      return s[15:8];
   endfunction

   function automatic logic signed [10:0] to_s11(input gray_t p);
      return signed'({3'b000, p});
   endfunction

endpackage

// File: rtl/edge_grayscale.sv
// rtl/edge_grayscale.sv - stage 1: registered RGB888 to 8-bit luma conversion
module edge_grayscale
   import edge_pkg::*;
(
   input  logic  I_PCLK,
   input  logic  I_RST_N,
   input  rgb_t  I_PIX,
   output gray_t O_PIXEL
);

   always_ff @(posedge I_PCLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         O_PIXEL <= '0;
      end else begin
         O_PIXEL <= rgb_to_gray(I_PIX);
      end
   end

endmodule

// File: rtl/edge_detection_top.sv
// rtl/edge_detection_top.sv - Sobel edge detector on a 640-wide RGB pixel stream
module edge_detection_top
   import edge_pkg::*;
(
   input  logic        I_PCLK,
   input  logic        I_RST_N,
   input  logic [23:0] I_PIX_DATA,
   input  logic        I_VSYNC,
   input  logic        I_HSYNC,
   input  logic        I_DE,
   output logic [23:0] O_PIX_DATA,
   output logic        O_VSYNC,
   output logic        O_HSYNC,
   output logic        O_DE,
   output logic        O_PCLK
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);

   logic [LAT-1:0] vs_d, hs_d, de_d;
   logic [X_W-1:0] x, x1, x2;
   logic [Y_W-1:0] y, y1, y2;
   logic           de_fall;
   gray_t          gray;
   gray_t          lb0 [H_ACTIVE];
   gray_t          lb1 [H_ACTIVE];
   gray_t          lb0_rd, lb1_rd;
   logic [X_W-1:0] lb_addr;
   logic           lb_en;
   gray_t [2:0][2:0] win;
   logic signed [10:0] gx, gy;
   logic [10:0]    ax, ay, sum;
   gray_t          sat, mag;
   logic           centre_ok;

   assign O_PCLK  = I_PCLK;
   assign de_fall = de_d[0] && !I_DE;

   always_ff @(posedge I_PCLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         vs_d <= '0;
         hs_d <= '0;
         de_d <= '0;
         x    <= '0;
         y    <= '0;
      end else begin
         vs_d <= {vs_d[LAT-2:0], I_VSYNC};
         hs_d <= {hs_d[LAT-2:0], I_HSYNC};
         de_d <= {de_d[LAT-2:0], I_DE};
         if (de_fall) begin
            x <= '0;
         end else if (I_DE) begin
            x <= x + 1'b1;
         end
         if (I_VSYNC) begin
            y <= '0;
         end else if (de_fall) begin
            y <= y + 1'b1;
         end
      end
   end

   edge_grayscale u_gray (
      .I_PCLK  (I_PCLK),
      .I_RST_N (I_RST_N),
      .I_PIX   (I_PIX_DATA),
      .O_PIXEL (gray)
   );

   // Guard keeps an overlong DE run from indexing past the line buffers.
   assign lb_en   = de_d[0] && (x1 <= X_LAST);
   assign lb_addr = (x1 <= X_LAST) ? x1 : '0;
   assign lb0_rd  = lb0[lb_addr];
   assign lb1_rd  = lb1[lb_addr];

   always_ff @(posedge I_PCLK) begin
      if (lb_en) begin
         lb1[lb_addr] <= lb0_rd;
         lb0[lb_addr] <= gray;
      end
   end

   always_ff @(posedge I_PCLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         x1  <= '0;
         y1  <= '0;
         x2  <= '0;
         y2  <= '0;
         win <= '0;
      end else begin
         x1 <= x;
         y1 <= y;
         x2 <= x1;
         y2 <= y1;
         if (de_d[0]) begin
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= gray;
         end
      end
   end

   // win[row][col]: row 0 is the oldest line, col 2 the newest pixel.
   always_comb begin
      gx  = (to_s11(win[0][2]) + (to_s11(win[1][2]) <<< 1) + to_s11(win[2][2]))
          - (to_s11(win[0][0]) + (to_s11(win[1][0]) <<< 1) + to_s11(win[2][0]));
      gy  = (to_s11(win[2][0]) + (to_s11(win[2][1]) <<< 1) + to_s11(win[2][2]))
          - (to_s11(win[0][0]) + (to_s11(win[0][1]) <<< 1) + to_s11(win[0][2]));
      ax  = gx[10] ? 11'(-gx) : 11'(gx);
      ay  = gy[10] ? 11'(-gy) : 11'(gy);
      sum = ax + ay;
      sat = (sum > 11'd255) ? 8'hFF : sum[7:0];
      centre_ok = de_d[1] && (x2 >= X_W'(2)) && (y2 >= Y_W'(2));
   end

   always_ff @(posedge I_PCLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         mag <= '0;
      end else begin
         mag <= centre_ok ? sat : '0;
      end
   end

   assign O_PIX_DATA = de_d[LAT-1] ? {3{mag}} : 24'h0;
   assign O_VSYNC    = vs_d[LAT-1];
   assign O_HSYNC    = hs_d[LAT-1];
   assign O_DE       = de_d[LAT-1];

endmodule

// File: tb/tb_edge_detection_top.sv
// tb/tb_edge_detection_top.sv - directed self-checking bench for edge_detection_top
module tb_edge_detection_top;

   localparam int H_ACT  = 640;
   localparam int H_TOT  = 660;
   localparam int N_ROWS = 6;
   localparam int V_TOT  = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] pix_in;
   logic        vs_in, hs_in, de_in;
   logic [23:0] O_PIX_DATA;
   logic        O_VSYNC, O_HSYNC, O_DE, O_PCLK;

   always #5 clk = ~clk;

   edge_detection_top dut (
      .I_PCLK     (clk),
      .I_RST_N    (rst_n),
      .I_PIX_DATA (pix_in),
      .I_VSYNC    (vs_in),
      .I_HSYNC    (hs_in),
      .I_DE       (de_in),
      .O_PIX_DATA (O_PIX_DATA),
      .O_VSYNC    (O_VSYNC),
      .O_HSYNC    (O_HSYNC),
      .O_DE       (O_DE),
      .O_PCLK     (O_PCLK)
   );

   typedef struct {
      logic [23:0] rgb;
      logic [7:0]  gray;
   } gvec_t;

   gvec_t gtab [8];

   int n_pass  = 0;
   int n_total = 0;
   int mode    = 0;
   bit chk_en  = 1'b0;

   int sync_err = 0;
   int pix_err  = 0;
   int npix     = 0;
   int orow     = 0;
   int ocol     = 0;
   int bad_row  = 0;
   int bad_col  = 0;
   logic [23:0] bad_got = '0;
   logic [23:0] bad_exp = '0;
   logic        prev_ode = 1'b0;
   logic [2:0]  h_de = '0, h_hs = '0, h_vs = '0;

   // Modes: 0 uniform grey, 1 black/white vertical step, 2 low vertical step, 3 grey-over-black horizontal step
   function automatic logic [23:0] in_pix(input int m, input int row, input int col);
      case (m)
         1:       return (col < 320) ? 24'h000000 : 24'hFFFFFF;
         2:       return (col < 320) ? 24'h000000 : 24'h101010;
         3:       return (row < 3)   ? 24'h202020 : 24'h000000;
         default: return 24'h808080;
      endcase
   endfunction

   function automatic logic [23:0] exp_pix(input int m, input int row, input int col);
      if (row < 2 || col < 2) return 24'h0;
      case (m)
         1:       return (col == 320 || col == 321) ? 24'hFFFFFF : 24'h0;
         2:       return (col == 320 || col == 321) ? 24'h404040 : 24'h0;
         3:       return (row == 3 || row == 4)     ? 24'h808080 : 24'h0;
         default: return 24'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         $display("FAIL %s: got %h want %h", name, got, want);
      end else begin
         n_pass++;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if ({O_VSYNC, O_HSYNC, O_DE} !== {h_vs[2], h_hs[2], h_de[2]}) sync_err <= sync_err + 1;
         if (O_DE) begin
            npix <= npix + 1;
            if (O_PIX_DATA !== exp_pix(mode, orow, ocol)) begin
               pix_err <= pix_err + 1;
               bad_row <= orow;
               bad_col <= ocol;
               bad_got <= O_PIX_DATA;
               bad_exp <= exp_pix(mode, orow, ocol);
            end
         end else if (O_PIX_DATA !== 24'h0) begin
            pix_err <= pix_err + 1;
            bad_row <= -1;
            bad_col <= -1;
            bad_got <= O_PIX_DATA;
            bad_exp <= 24'h0;
         end
      end
      h_de     <= {h_de[1:0], de_in};
      h_hs     <= {h_hs[1:0], hs_in};
      h_vs     <= {h_vs[1:0], vs_in};
      prev_ode <= O_DE;
      if (O_VSYNC) begin
         orow <= 0;
         ocol <= 0;
      end else if (O_DE) begin
         ocol <= ocol + 1;
      end else if (prev_ode) begin
         orow <= orow + 1;
         ocol <= 0;
      end
   end

   // rl >= 0 pulses reset in the middle of line rl
   task automatic run_frame(input int m, input int rl);
      for (int ln = 0; ln < V_TOT; ln++) begin
         for (int h = 0; h < H_TOT; h++) begin
            if (ln == rl && h == 324) begin
               chk("pre-reset pixel", 32'(O_PIX_DATA), 32'hFFFFFF);
               rst_n = 1'b0;
               #1;
               chk("async reset de", 32'(O_DE), 32'h0);
               chk("async reset pix", 32'(O_PIX_DATA), 32'h0);
            end
            if (ln == rl && h == 340) rst_n = 1'b1;
            vs_in  = (ln < 2);
            hs_in  = (h >= 644 && h < 652);
            de_in  = (ln >= 3 && ln < 3 + N_ROWS && h < H_ACT);
            pix_in = de_in ? in_pix(m, ln - 3, h) : 24'h0;
            @(posedge clk);
            #1;
            if (ln == rl && h == 330) begin
               chk("held reset de", 32'(O_DE), 32'h0);
               chk("held reset pix", 32'(O_PIX_DATA), 32'h0);
               chk("held reset gray", 32'(dut.u_gray.O_PIXEL), 32'h0);
            end
         end
      end
   endtask

   task automatic check_frame(input string name, input int m);
      int s0, p0, n0;
      mode   = m;
      s0     = sync_err;
      p0     = pix_err;
      n0     = npix;
      chk_en = 1'b1;
      run_frame(m, -1);
      chk({name, " sync delay"}, 32'(sync_err - s0), 32'h0);
      chk({name, " pixel count"}, 32'(npix - n0), 32'(H_ACT * N_ROWS));
      n_total++;
      if (pix_err != p0) begin
         $display("FAIL %s pixels: %0d wrong, last row %0d col %0d got %h want %h",
                  name, pix_err - p0, bad_row, bad_col, bad_got, bad_exp);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      gtab[0] = '{24'hFF0000, 8'd76};
      gtab[1] = '{24'h00FF00, 8'd149};
      gtab[2] = '{24'h0000FF, 8'd28};
      gtab[3] = '{24'hFFFFFF, 8'd255};
      gtab[4] = '{24'h000000, 8'd0};
      gtab[5] = '{24'h808080, 8'd128};
      gtab[6] = '{24'h102030, 8'd29};
      gtab[7] = '{24'h123456, 8'd45};

      rst_n  = 1'b0;
      pix_in = 24'hFFFFFF;
      vs_in  = 1'b1;
      hs_in  = 1'b1;
      de_in  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("reset O_DE", 32'(O_DE), 32'h0);
      chk("reset O_VSYNC", 32'(O_VSYNC), 32'h0);
      chk("reset O_HSYNC", 32'(O_HSYNC), 32'h0);
      chk("reset O_PIX_DATA", 32'(O_PIX_DATA), 32'h0);
      chk("reset gray", 32'(dut.u_gray.O_PIXEL), 32'h0);
      chk("pclk high", 32'(O_PCLK), 32'h1);
      #5;
      chk("pclk low", 32'(O_PCLK), 32'h0);

      @(posedge clk);
      #1;
      pix_in = 24'h0;
      vs_in  = 1'b0;
      hs_in  = 1'b0;
      de_in  = 1'b0;
      rst_n  = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         pix_in = gtab[i].rgb;
         @(posedge clk);
         #1;
         chk($sformatf("gray %h", gtab[i].rgb), 32'(dut.u_gray.O_PIXEL), 32'(gtab[i].gray));
      end
      pix_in = 24'h0;

      check_frame("uniform", 0);
      check_frame("vstep white", 1);
      check_frame("vstep low", 2);
      check_frame("hstep low", 3);

      chk_en = 1'b0;
      mode   = 1;
      run_frame(1, 5);

      check_frame("uniform after reset", 0);
      check_frame("vstep after reset", 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
